// File: rtl/dmem_wait_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the
// multi-cycle data-memory responder (slave).
interface dmem_wait_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        mem_stall;
   logic        mem_err;

   modport master (
      output mem_read, mem_write, addr, write_data,
      input  read_data, mem_stall, mem_err
   );

   modport slave (
      input  mem_read, mem_write, addr, write_data,
      output read_data, mem_stall, mem_err
   );
endinterface

// File: rtl/dmem_wait_responder.sv
// Multi-cycle data memory: stalls the pipeline for WAIT_CYCLES cycles per
// load/store, then commits the store or returns the load in the DONE cycle.
module dmem_wait_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst,
   dmem_wait_responder_if.slave bus
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        req_rd_q, req_wr_q;
   logic [31:0] req_addr_q, req_data_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] read_data_q;
   logic        err_q;
   logic        stall;

   logic             request;
   logic             commit;
   logic             acc_rd, acc_wr;
   logic [31:0]      acc_addr, acc_data;
   logic             acc_fault;
   logic [IDX_W-1:0] acc_idx;

   assign request = bus.mem_read | bus.mem_write;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         S_IDLE: begin
            stall = request;
            if (request) state_nxt = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            stall = 1'b1;
            if (cnt == 4'd1) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // With a single wait state the access happens straight out of IDLE, so the
   // live bus is used; otherwise the request captured in IDLE.
   always_comb begin
      if (state == S_IDLE) begin
         acc_rd   = bus.mem_read;
         acc_wr   = bus.mem_write;
         acc_addr = bus.addr;
         acc_data = bus.write_data;
      end else begin
         acc_rd   = req_rd_q;
         acc_wr   = req_wr_q;
         acc_addr = req_addr_q;
         acc_data = req_data_q;
      end
   end

   assign commit    = (state_nxt == S_DONE);
   assign acc_idx   = acc_addr[IDX_W+1:2];
   assign acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT) ||
                      (acc_rd && acc_wr);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= 4'd0;
         req_rd_q   <= 1'b0;
         req_wr_q   <= 1'b0;
         req_addr_q <= 32'd0;
         req_data_q <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (request) begin
                  req_rd_q   <= bus.mem_read;
                  req_wr_q   <= bus.mem_write;
                  req_addr_q <= bus.addr;
                  req_data_q <= bus.write_data;
                  cnt        <= 4'(WAIT_CYCLES - 1);
               end
            end
            S_WAIT:  if (cnt != 4'd1) cnt <= cnt - 4'd1;
            default: ;
         endcase
      end
   end

   // NOTE: the array is deliberately not reset; reset only blocks a store
   // that has not yet committed.
   always_ff @(posedge clk) begin
      if (!rst && commit && acc_wr && !acc_fault) mem[acc_idx] <= acc_data;
   end

   // mem_err is set on the edge entering DONE and cleared on the edge leaving it.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data_q <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (commit) begin
            if (acc_fault) begin
               read_data_q <= 32'd0;
               err_q       <= 1'b1;
            end else if (acc_rd) begin
               read_data_q <= mem[acc_idx];
            end
         end
      end
   end

   assign bus.mem_stall = stall;
   assign bus.read_data = read_data_q;
   assign bus.mem_err   = err_q;

endmodule
